// File: rtl/control_sequencer_pkg.sv
// Shared state and opcode encodings for the control sequencer and its datapath neighbours.
// ST_PAUSE is only reachable when CTRL_SINGLE_STEP_EN is defined.
package control_sequencer_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_EXECUTE   = 3'd3;
  localparam logic [2:0] ST_WRITEBACK = 3'd4;
  localparam logic [2:0] ST_HALT      = 3'd5;
  localparam logic [2:0] ST_PAUSE     = 3'd6;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUBI = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  function automatic logic is_imm_op(input logic [2:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control/status bundle between the sequencer (master) and the datapath (slave).
// CTRL_SINGLE_STEP_EN adds the step input.
interface control_sequencer_if #(
  parameter int unsigned OPC_W = 3,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             stall;
  logic [OPC_W-1:0] opcode;
  logic             regs_equal;
`ifdef CTRL_SINGLE_STEP_EN
  logic             step;
`endif
  logic             ir_load;
  logic             pc_inc;
  logic             pc_branch;
  logic             reg_we;
  logic             alu_imm_sel;
  logic             busy;
  logic             halted;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state;

  modport master (
`ifdef CTRL_SINGLE_STEP_EN
    input  step,
`endif
    input  start, stall, opcode, regs_equal,
    output ir_load, pc_inc, pc_branch, reg_we, alu_imm_sel,
    output busy, halted, retired, state
  );

  modport slave (
`ifdef CTRL_SINGLE_STEP_EN
    output step,
`endif
    output start, stall, opcode, regs_equal,
    input  ir_load, pc_inc, pc_branch, reg_we, alu_imm_sel,
    input  busy, halted, retired, state
  );
endinterface

// File: rtl/control_sequencer_retire_counter.sv
// Saturating retired-instruction counter with synchronous active-high reset.
module retire_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset)
      r_count <= '0;
    else if (i_inc && (r_count != '1))
      r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control FSM for the 16-bit datapath.
// Optional single-step PAUSE state: define CTRL_SINGLE_STEP_EN.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int unsigned OPC_W = 3,
  parameter int unsigned CNT_W = 16
) (
  input logic                 clk,
  input logic                 reset,
  control_sequencer_if.master bus
);

`ifdef CTRL_SINGLE_STEP_EN
  localparam logic [2:0] ST_RESUME = ST_PAUSE;
`else
  localparam logic [2:0] ST_RESUME = ST_FETCH;
`endif

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [OPC_W-1:0] w_op;
  logic             w_ir, w_inc, w_br, w_we, w_imm, w_ret, w_stallable;
  logic [CNT_W-1:0] w_retired;

  assign w_op        = bus.opcode;
  assign w_stallable = (r_state == ST_FETCH) || (r_state == ST_DECODE) ||
                       (r_state == ST_EXECUTE) || (r_state == ST_WRITEBACK);

  always_comb begin
    w_next = r_state;
    w_ir   = 1'b0;
    w_inc  = 1'b0;
    w_br   = 1'b0;
    w_we   = 1'b0;
    w_imm  = 1'b0;
    w_ret  = 1'b0;
    case (r_state)
      ST_IDLE:   if (bus.start) w_next = ST_FETCH;
      ST_FETCH: begin
        w_ir   = 1'b1;
        w_next = ST_DECODE;
      end
      ST_DECODE: begin
        w_imm  = is_imm_op(w_op);
        w_next = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        w_imm = is_imm_op(w_op);
        w_ret = 1'b1;
        if (w_op == OP_HALT) begin
          w_next = ST_HALT;
        end else if (is_alu_op(w_op)) begin
          w_ret  = 1'b0;
          w_next = ST_WRITEBACK;
        end else if (w_op == OP_BEQ) begin
          w_br   = bus.regs_equal;
          w_inc  = !bus.regs_equal;
          w_next = ST_RESUME;
        end else begin
          w_inc  = 1'b1;
          w_next = ST_RESUME;
        end
      end
      ST_WRITEBACK: begin
        w_we   = 1'b1;
        w_inc  = 1'b1;
        w_imm  = is_imm_op(w_op);
        w_ret  = 1'b1;
        w_next = ST_RESUME;
      end
      ST_HALT: w_next = ST_HALT;
`ifdef CTRL_SINGLE_STEP_EN
      ST_PAUSE: if (bus.step) w_next = ST_FETCH;
`endif
      default: w_next = ST_IDLE;
    endcase

    // Stall freezes state and side-effect strobes but leaves alu_imm_sel alone.
    if (bus.stall && w_stallable) begin
      w_next = r_state;
      w_ir   = 1'b0;
      w_inc  = 1'b0;
      w_br   = 1'b0;
      w_we   = 1'b0;
      w_ret  = 1'b0;
    end
    if (reset) begin
      w_ir  = 1'b0;
      w_inc = 1'b0;
      w_br  = 1'b0;
      w_we  = 1'b0;
      w_ret = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  retire_counter #(.CNT_W(CNT_W)) u_retire (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_ret),
    .o_count (w_retired)
  );

  assign bus.ir_load     = w_ir;
  assign bus.pc_inc      = w_inc;
  assign bus.pc_branch   = w_br;
  assign bus.reg_we      = w_we;
  assign bus.alu_imm_sel = w_imm;
  assign bus.busy        = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign bus.halted      = (r_state == ST_HALT);
  assign bus.retired     = w_retired;
  assign bus.state       = r_state;

endmodule
